// File: rtl/aes_core_arbiter_if.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter_if
// Bundles every handshake and bus signal around the shared AES core arbiter:
// the two requester channels, the core-side control/data, and the response
// channel.
//   master : the arbiter (drives req_ready, core_*, rsp_*, busy)
//   slave  : the environment (requesters, AES core, response consumer)
// Parameter DATA_W sets the plaintext/key/ciphertext width.
// ---------------------------------------------------------------------------
interface aes_core_arbiter_if #(
  parameter int DATA_W = 128
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req0_key;
  logic [DATA_W-1:0] req1_data;
  logic [DATA_W-1:0] req1_key;
  logic              core_rst;
  logic              core_en;
  logic [DATA_W-1:0] core_data;
  logic [DATA_W-1:0] core_key;
  logic              core_done;
  logic [DATA_W-1:0] core_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    input  req_valid, req0_data, req0_key, req1_data, req1_key,
    input  core_done, core_dout, rsp_ready,
    output req_ready, core_rst, core_en, core_data, core_key,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req0_data, req0_key, req1_data, req1_key,
    output core_done, core_dout, rsp_ready,
    input  req_ready, core_rst, core_en, core_data, core_key,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter
// Shares one AES-128 core between two requesters. Round-robin arbitration in
// IDLE latches the winner's plaintext/key, then the core is held in reset for
// RST_CYCLES cycles, enabled until core_done, and the ciphertext is returned
// with the requester ID over a valid/ready response channel.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : aes_core_arbiter_if.master (requests, core control, response)
// Parameters: DATA_W (bus width), RST_CYCLES (1..15), TIMEOUT (1..255).
// Optional feature: define AES_ARB_TIMEOUT_EN to abort a RUN phase that sees
// no core_done within TIMEOUT cycles (response then carries rsp_err=1 and
// zero data). Without it rsp_err is tied low and RUN waits indefinitely.
// ---------------------------------------------------------------------------
module aes_core_arbiter #(
  parameter int DATA_W     = 128,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                reset,
  aes_core_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, GRANT_RST, RUN, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_id;
  logic              r_rsp_id;
  logic [3:0]        r_rst_cnt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] r_rsp_data;
  logic [1:0]        w_req_ready;
  logic              w_winner;
  logic              w_grant;
  logic              w_done;
  logic              w_timeout;
  logic              w_accept;

`ifdef AES_ARB_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_rsp_err;

  // Held at zero outside RUN, so it starts from zero on every RUN entry.
  // In RUN cycle k the counter holds k-1; the abort fires in cycle TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state != RUN) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == RUN) && (r_to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_done) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_winner    = 1'b0;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        // Gating with reset keeps req_ready low while reset is asserted.
        if (reset && (bus.req_valid != 2'b00)) begin
          // On a tie the requester that was not served last wins.
          w_winner    = (bus.req_valid == 2'b11) ? ~r_last_id : bus.req_valid[1];
          w_grant     = 1'b1;
          w_req_ready = w_winner ? 2'b10 : 2'b01;
          w_state_nxt = GRANT_RST;
        end
      end
      GRANT_RST: begin
        if (r_rst_cnt == 4'd0) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // core_done takes priority over a coincident timeout.
        if (bus.core_done) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job latches, reset down-counter, response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_id  <= 1'b1;
      r_rsp_id   <= 1'b0;
      r_rst_cnt  <= '0;
      r_data     <= '0;
      r_key      <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_grant) begin
        r_data    <= w_winner ? bus.req1_data : bus.req0_data;
        r_key     <= w_winner ? bus.req1_key  : bus.req0_key;
        r_rsp_id  <= w_winner;
        r_rst_cnt <= 4'(RST_CYCLES - 1);
      end else if ((r_state == GRANT_RST) && (r_rst_cnt != 4'd0)) begin
        r_rst_cnt <= r_rst_cnt - 4'd1;
      end
      if (w_done) begin
        r_rsp_data <= bus.core_dout;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
      end
      if (w_accept) begin
        r_last_id <= r_rsp_id;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.core_rst  = (r_state == GRANT_RST);
  assign bus.core_en   = (r_state == RUN);
  assign bus.core_data = r_data;
  assign bus.core_key  = r_key;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_core_arbiter
// Drives the shared-AES arbiter with directed scenarios and randomized
// traffic. A simple core stand-in answers core_en after a programmable
// delay. A job-level reference model (cycles elapsed since grant, response
// pending flag, last served ID) predicts every output on every falling edge.
// ---------------------------------------------------------------------------
module tb_aes_core_arbiter;
  localparam int DW   = 128;
  localparam int RSTC = 2;
  localparam int TO   = 64;
`ifdef AES_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_core_arbiter_if #(.DATA_W(DW)) ifc();

  aes_core_arbiter #(.DATA_W(DW), .RST_CYCLES(RSTC), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int n_checks = 0;
  int n_err    = 0;
  int done_delay = 3;
  bit glitch_en  = 1'b0;
  int fc_cnt     = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the AES core: known-answer vector, otherwise a fixed mix.
  function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k);
    if (d == PT && k == KEY) return CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Core stand-in: raises core_done once core_en has been high done_delay
  // cycles (0 = never); optionally toggles core_done randomly while disabled.
  initial begin
    ifc.core_done = 1'b0;
    ifc.core_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset || !ifc.core_en) begin
        fc_cnt        = 0;
        ifc.core_done = glitch_en ? 1'($urandom % 2) : 1'b0;
        ifc.core_dout = rnd128();
      end else begin
        fc_cnt++;
        if (done_delay != 0 && fc_cnt >= done_delay) begin
          ifc.core_done = 1'b1;
          ifc.core_dout = core_f(ifc.core_data, ifc.core_key);
        end else begin
          ifc.core_done = 1'b0;
          ifc.core_dout = rnd128();
        end
      end
    end
  end

  // Reference model: one job at a time, tracked by cycles since its grant.
  logic         m_job  = 1'b0;
  logic         m_resp = 1'b0;
  logic         m_last = 1'b1;
  logic         m_id   = 1'b0;
  logic         m_err  = 1'b0;
  int           m_t    = 0;
  int           m_run  = 0;
  logic [127:0] m_d = '0, m_k = '0, m_r = '0;
  logic [1:0]   e_rr;

  always @(negedge clk) begin
    if (!reset) begin
      m_job = 1'b0; m_resp = 1'b0; m_last = 1'b1;
      chk("rst_req_ready", ifc.req_ready, 0);
      chk("rst_core_rst",  ifc.core_rst,  0);
      chk("rst_core_en",   ifc.core_en,   0);
      chk("rst_rsp_valid", ifc.rsp_valid, 0);
      chk("rst_rsp_id",    ifc.rsp_id,    0);
      chk("rst_rsp_data",  ifc.rsp_data,  0);
      chk("rst_rsp_err",   ifc.rsp_err,   0);
      chk("rst_busy",      ifc.busy,      0);
      chk("rst_core_data", ifc.core_data, 0);
      chk("rst_core_key",  ifc.core_key,  0);
    end else if (!m_job) begin
      if (ifc.req_valid == 2'b11) e_rr = m_last ? 2'b01 : 2'b10;
      else                        e_rr = ifc.req_valid;
      chk("idle_req_ready", ifc.req_ready, e_rr);
      chk("idle_busy",      ifc.busy,      0);
      chk("idle_core_rst",  ifc.core_rst,  0);
      chk("idle_core_en",   ifc.core_en,   0);
      chk("idle_rsp_valid", ifc.rsp_valid, 0);
      if (e_rr != 2'b00) begin
        m_job = 1'b1; m_resp = 1'b0; m_t = 0;
        m_id  = e_rr[1];
        m_d   = m_id ? ifc.req1_data : ifc.req0_data;
        m_k   = m_id ? ifc.req1_key  : ifc.req0_key;
      end
    end else if (m_resp) begin
      chk("resp_valid",     ifc.rsp_valid, 1);
      chk("resp_busy",      ifc.busy,      1);
      chk("resp_core_en",   ifc.core_en,   0);
      chk("resp_core_rst",  ifc.core_rst,  0);
      chk("resp_req_ready", ifc.req_ready, 0);
      chk("resp_id",        ifc.rsp_id,    m_id);
      chk("resp_data",      ifc.rsp_data,  m_r);
      chk("resp_err",       ifc.rsp_err,   m_err);
      if (ifc.rsp_ready) begin
        m_job = 1'b0; m_resp = 1'b0; m_last = m_id;
      end
    end else begin
      m_t++;
      chk("job_busy",      ifc.busy,      1);
      chk("job_rsp_valid", ifc.rsp_valid, 0);
      chk("job_req_ready", ifc.req_ready, 0);
      chk("job_core_data", ifc.core_data, m_d);
      chk("job_core_key",  ifc.core_key,  m_k);
      if (m_t <= RSTC) begin
        chk("rstph_core_rst", ifc.core_rst, 1);
        chk("rstph_core_en",  ifc.core_en,  0);
      end else begin
        chk("run_core_rst", ifc.core_rst, 0);
        chk("run_core_en",  ifc.core_en,  1);
        m_run = m_t - RSTC;
        if (ifc.core_done) begin
          m_resp = 1'b1; m_r = ifc.core_dout; m_err = 1'b0;
        end else if (TO_EN && m_run >= TO) begin
          m_resp = 1'b1; m_r = '0; m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns at the falling edge of the grant cycle.
  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 300 && g == 2'b00; i++) begin
      @(negedge clk);
      if (ifc.req_ready != 2'b00) g = ifc.req_ready;
    end
    if (g == 2'b00) begin
      n_checks++; n_err++;
      $display("FAIL grant_wait: req_ready stayed 00 for 300 cycles, expected a grant");
    end
  endtask

  // Returns at the falling edge of the first rsp_valid cycle.
  task automatic wait_resp(output logic [127:0] d, output logic id, output logic err, output int en_n);
    bit got = 1'b0;
    d = '0; id = 1'b0; err = 1'b0; en_n = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ifc.core_en) en_n++;
      if (ifc.rsp_valid) begin
        got = 1'b1; d = ifc.rsp_data; id = ifc.rsp_id; err = ifc.rsp_err;
      end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL resp_wait: rsp_valid stayed 0 for 300 cycles, expected a response");
    end
  endtask

  logic [1:0]   g;
  logic [127:0] d, ds;
  logic         id, err;
  int           en_n, rst_n, first_en, first_v, stale;
  logic [1:0]   t2_exp [3];

  initial begin
    ifc.req_valid = 2'b00;
    ifc.req0_data = '0; ifc.req0_key = '0;
    ifc.req1_data = '0; ifc.req1_key = '0;
    ifc.rsp_ready = 1'b0;
    t2_exp = '{2'b01, 2'b10, 2'b01};
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // T1: known-answer single request from requester 0
    ifc.req0_data = PT; ifc.req0_key = KEY;
    ifc.req_valid = 2'b01; ifc.rsp_ready = 1'b1; done_delay = 3;
    wait_grant(g); chk("t1_grant", g, 2'b01);
    tick(); ifc.req_valid = 2'b00;
    wait_resp(d, id, err, en_n);
    chk("t1_data", d, CT); chk("t1_id", id, 0); chk("t1_err", err, 0);
    tick();

    // T2: tie after reset alternates 01, 10, 01
    reset = 1'b0; tick(); reset = 1'b1;
    ifc.req1_data = rnd128(); ifc.req1_key = rnd128();
    ifc.req_valid = 2'b11; done_delay = 2;
    for (int i = 0; i < 3; i++) begin
      wait_grant(g); chk("t2_grant", g, t2_exp[i]);
      tick();
      wait_resp(d, id, err, en_n);
      chk("t2_id", id, t2_exp[i][1]);
      tick();
    end
    ifc.req_valid = 2'b00;

    // T3: response backpressure, no grant until after acceptance
    ifc.rsp_ready = 1'b0; ifc.req_valid = 2'b01;
    wait_grant(g); tick(); ifc.req_valid = 2'b00;
    wait_resp(ds, id, err, en_n);
    tick(); ifc.req_valid = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_valid", ifc.rsp_valid, 1);
      chk("t3_data", ifc.rsp_data, ds);
      chk("t3_no_grant", ifc.req_ready, 0);
      tick();
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clk); chk("t3_accept_no_grant", ifc.req_ready, 0);
    tick();
    @(negedge clk); chk("t3_grant_after", ifc.req_ready, 2'b10);
    tick(); ifc.req_valid = 2'b00;
    wait_resp(d, id, err, en_n); chk("t3_id2", id, 1);
    tick();

    // T4: timing with RST_CYCLES=2 and core_done in RUN cycle 5
    done_delay = 5; ifc.req_valid = 2'b01;
    wait_grant(g);
    rst_n = 0; en_n = 0; first_en = 0; first_v = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(); ifc.req_valid = 2'b00;
      @(negedge clk);
      if (ifc.core_rst) rst_n++;
      if (ifc.core_en) begin
        en_n++;
        if (first_en == 0) first_en = c;
      end
      if (ifc.rsp_valid && first_v == 0) first_v = c;
    end
    chk("t4_rst_cycles", rst_n, 2);
    chk("t4_first_en", first_en, 3);
    chk("t4_en_cycles", en_n, 5);
    chk("t4_first_valid", first_v, 8);
    tick();

    // T5: reset in the middle of RUN
    done_delay = 20; ifc.req_valid = 2'b01;
    wait_grant(g); tick(); ifc.req_valid = 2'b00;
    first_en = 0;
    for (int i = 0; i < 20 && first_en == 0; i++) begin
      @(negedge clk);
      if (ifc.core_en) first_en = 1;
    end
    chk("t5_en_seen", first_en, 1);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", ifc.busy, 0); chk("t5_core_en", ifc.core_en, 0);
    chk("t5_core_data", ifc.core_data, 0);
    tick(); reset = 1'b1; done_delay = 3;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid) stale++;
    end
    chk("t5_no_stale", stale, 0);
    tick();
    ifc.req1_data = rnd128(); ifc.req1_key = rnd128(); ifc.req_valid = 2'b10;
    wait_grant(g); chk("t5_grant", g, 2'b10);
    tick(); ifc.req_valid = 2'b00;
    wait_resp(d, id, err, en_n);
    chk("t5_id", id, 1); chk("t5_err", err, 0);
    chk("t5_data", d, core_f(ifc.req1_data, ifc.req1_key));
    tick();

`ifdef AES_ARB_TIMEOUT_EN
    // T6: timeout abort, then core_done coincident with the limit
    done_delay = 0; ifc.req_valid = 2'b01;
    wait_grant(g); tick(); ifc.req_valid = 2'b00;
    wait_resp(d, id, err, en_n);
    chk("t6_to_err", err, 1); chk("t6_to_data", d, 0); chk("t6_to_run", en_n, 64);
    tick();
    done_delay = 64; ifc.req_valid = 2'b01;
    wait_grant(g); tick(); ifc.req_valid = 2'b00;
    wait_resp(d, id, err, en_n);
    chk("t6_hit_err", err, 0); chk("t6_hit_run", en_n, 64);
    chk("t6_hit_data", d, core_f(ifc.req0_data, ifc.req0_key));
    tick();
`endif

    // Randomized traffic with occasional resets and stray core_done
    glitch_en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      ifc.req_valid = 2'($urandom);
      ifc.req0_data = rnd128(); ifc.req0_key = rnd128();
      ifc.req1_data = rnd128(); ifc.req1_key = rnd128();
      ifc.rsp_ready = ($urandom % 4) != 0;
      done_delay    = 1 + ($urandom % 8);
      reset         = ($urandom % 400) != 0;
      tick();
    end
    reset = 1'b1; ifc.req_valid = 2'b00; ifc.rsp_ready = 1'b1; glitch_en = 1'b0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
